fdse_pipe: RTL and testbench

//  Parametrised WIDTH x DEPTH delay line of sync-set, clock-enabled D flops.

---
 rtl/fdse_pkg.sv | 12 +
 rtl/fdse_stage.sv | 58 +++++
 rtl/fdse_pipe.sv | 113 +++++++++++
 tb/tb_fdse_pipe.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fdse_pkg.sv
// Shared constants and helpers for the fdse_pipe delay line.
package fdse_pkg;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;

  // Width of a counter that must reach depth inclusive.
  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fdse_stage.sv
// One vector register with FDSE/FDSE_1 semantics: R_N low > S high > CE high > hold.
// Optional FDSE_PIPE_GSR_EN adds an asynchronous glbl.GSR force to INIT.
module fdse_stage
  import fdse_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b1}},
  parameter int               EDGE  = EDGE_FALL
) (
  input  logic             C,
  input  logic             R_N,
  input  logic             CE,
  input  logic             S,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (!R_N) begin
      q_d = INIT;
    end else if (S) begin
      q_d = {WIDTH{1'b1}};
    end else if (CE) begin
      q_d = D;
    end
  end

`ifdef FDSE_PIPE_GSR_EN
  // GSR overrides the clocked path while high, so plain always blocks are used here.
  generate
    if (EDGE == EDGE_RISE) begin : g_rise
      always @(posedge C) q_q <= q_d;
    end else begin : g_fall
      always @(negedge C) q_q <= q_d;
    end
  endgenerate

  always @(glbl.GSR) begin
    if (glbl.GSR) assign q_q = INIT;
    else          deassign q_q;
  end
`else
  generate
    if (EDGE == EDGE_RISE) begin : g_rise
      always_ff @(posedge C) q_q <= q_d;
    end else begin : g_fall
      always_ff @(negedge C) q_q <= q_d;
    end
  endgenerate
`endif

  assign Q = q_q;

endmodule

// File: rtl/fdse_pipe.sv
// WIDTH x DEPTH delay line of fdse_stage registers with FILL/VALID tracking.
// Optional FDSE_PIPE_GSR_EN makes glbl.GSR clear FILL/VALID asynchronously.
module fdse_pipe
  import fdse_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b1}},
  parameter int               EDGE  = EDGE_FALL
) (
  input  logic                      C,
  input  logic                      R_N,
  input  logic                      CE,
  input  logic                      S,
  input  logic [WIDTH-1:0]          D,
  output logic [WIDTH-1:0]          Q,
  output logic [fill_w(DEPTH)-1:0]  FILL,
  output logic                      VALID
);

  localparam int FW = fill_w(DEPTH);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] stage_d;
      if (i == 0) begin : g_head
        assign stage_d = D;
      end else begin : g_link
        assign stage_d = stage_q[i-1];
      end

      fdse_stage #(
        .WIDTH (WIDTH),
        .INIT  (INIT),
        .EDGE  (EDGE)
      ) u_stage (
        .C   (C),
        .R_N (R_N),
        .CE  (CE),
        .S   (S),
        .D   (stage_d),
        .Q   (stage_q[i])
      );
    end
  endgenerate

  assign Q = stage_q[DEPTH-1];

  logic [FW-1:0] fill_q;
  logic [FW-1:0] fill_d;
  logic          valid_q;
  logic          valid_d;

  // FILL saturates at DEPTH; VALID is registered from the next-state count.
  always_comb begin
    fill_d = fill_q;
    if (!R_N) begin
      fill_d = '0;
    end else if (S) begin
      fill_d = FULL;
    end else if (CE && (fill_q != FULL)) begin
      fill_d = fill_q + FW'(1);
    end
    valid_d = (fill_d == FULL);
  end

`ifdef FDSE_PIPE_GSR_EN
  generate
    if (EDGE == EDGE_RISE) begin : g_cnt_rise
      always @(posedge C) begin
        fill_q  <= fill_d;
        valid_q <= valid_d;
      end
    end else begin : g_cnt_fall
      always @(negedge C) begin
        fill_q  <= fill_d;
        valid_q <= valid_d;
      end
    end
  endgenerate

  always @(glbl.GSR) begin
    if (glbl.GSR) begin
      assign fill_q  = '0;
      assign valid_q = 1'b0;
    end else begin
      deassign fill_q;
      deassign valid_q;
    end
  end
`else
  generate
    if (EDGE == EDGE_RISE) begin : g_cnt_rise
      always_ff @(posedge C) begin
        fill_q  <= fill_d;
        valid_q <= valid_d;
      end
    end else begin : g_cnt_fall
      always_ff @(negedge C) begin
        fill_q  <= fill_d;
        valid_q <= valid_d;
      end
    end
  endgenerate
`endif

  assign FILL  = fill_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_fdse_pipe.sv
// Scoreboard bench: a falling-edge and a rising-edge fdse_pipe share one stimulus stream.
module tb_fdse_pipe;

  localparam int         W    = 8;
  localparam int         DP   = 4;
  localparam int         FW   = 3;
  localparam logic [7:0] INIT = 8'hA5;

  logic          C;
  logic          R_N;
  logic          CE;
  logic          S;
  logic [W-1:0]  D;
  logic [W-1:0]  q_f, q_r;
  logic [FW-1:0] fill_f, fill_r;
  logic          vld_f, vld_r;

  fdse_pipe #(.WIDTH(W), .DEPTH(DP), .INIT(INIT), .EDGE(0)) u_fall (
    .C(C), .R_N(R_N), .CE(CE), .S(S), .D(D), .Q(q_f), .FILL(fill_f), .VALID(vld_f)
  );

  fdse_pipe #(.WIDTH(W), .DEPTH(DP), .INIT(INIT), .EDGE(1)) u_rise (
    .C(C), .R_N(R_N), .CE(CE), .S(S), .D(D), .Q(q_r), .FILL(fill_r), .VALID(vld_r)
  );

  initial C = 1'b0;
  always #10 C = ~C;

  typedef struct packed {
    logic [W-1:0]  q;
    logic [FW-1:0] fill;
    logic          valid;
  } exp_t;

  exp_t exp_f[$];
  exp_t exp_r[$];
  exp_t last_f, last_r;
  bit   have_f = 0;
  bit   have_r = 0;

  int checks = 0;
  int passed = 0;

  // Reference model: the pipe contents as a queue, oldest entry at the back.
  logic [W-1:0] m_pipe[$];
  int           m_fill;

  task automatic check(input string name, input logic [W-1:0] q, input logic [FW-1:0] f,
                       input logic v, input exp_t e);
    checks++;
    if (q === e.q && f === e.fill && v === e.valid) begin
      passed++;
    end else begin
      $display("FAIL %s @%0t: got Q=%h FILL=%0d VALID=%b, expected Q=%h FILL=%0d VALID=%b",
               name, $time, q, f, v, e.q, e.fill, e.valid);
    end
  endtask

  task automatic apply(input logic r_n, input logic s, input logic ce, input logic [W-1:0] d);
    exp_t e;
    @(posedge C);
    #5;
    R_N = r_n;
    S   = s;
    CE  = ce;
    D   = d;
    if (!r_n) begin
      m_pipe = {};
      for (int i = 0; i < DP; i++) m_pipe.push_back(INIT);
      m_fill = 0;
    end else if (s) begin
      m_pipe = {};
      for (int i = 0; i < DP; i++) m_pipe.push_back(8'hFF);
      m_fill = DP;
    end else if (ce) begin
      m_pipe.push_front(d);
      void'(m_pipe.pop_back());
      m_fill = (m_fill < DP) ? m_fill + 1 : DP;
    end
    e.q     = m_pipe[DP-1];
    e.fill  = FW'(m_fill);
    e.valid = (m_fill == DP);
    exp_f.push_back(e);
    exp_r.push_back(e);
  endtask

  // Falling-edge monitor: falling DUT must update, rising DUT must hold.
  always @(negedge C) begin
    #1;
    if (exp_f.size() > 0) begin
      last_f = exp_f.pop_front();
      have_f = 1;
      check("fall_update", q_f, fill_f, vld_f, last_f);
    end
    if (have_r) check("rise_hold_on_negedge", q_r, fill_r, vld_r, last_r);
  end

  // Rising-edge monitor: rising DUT must update, falling DUT must hold.
  always @(posedge C) begin
    #1;
    if (exp_r.size() > 0) begin
      last_r = exp_r.pop_front();
      have_r = 1;
      check("rise_update", q_r, fill_r, vld_r, last_r);
    end
    if (have_f) check("fall_hold_on_posedge", q_f, fill_f, vld_f, last_f);
  end

  initial begin
    R_N = 1'b0;
    S   = 1'b0;
    CE  = 1'b0;
    D   = '0;
    for (int i = 0; i < DP; i++) m_pipe.push_back(INIT);
    m_fill = 0;

    // Reset for two edges.
    apply(0, 0, 0, 8'h3C);
    apply(0, 0, 1, 8'h77);

    // Fill with 1..5.
    for (int i = 1; i <= 5; i++) apply(1, 0, 1, W'(i));

    // Stall three edges, then resume.
    for (int i = 0; i < 3; i++) apply(1, 0, 0, 8'hEE);
    for (int i = 6; i <= 9; i++) apply(1, 0, 1, W'(i));

    // Reset beats set and enable, then set alone.
    apply(0, 1, 1, 8'h55);
    apply(1, 1, 0, 8'h66);
    apply(1, 1, 1, 8'h12);
    for (int i = 0; i < 3; i++) apply(1, 0, 1, W'(8'h20 + i));

    // Reset mid-fill discards partial data.
    apply(0, 0, 0, 8'h00);
    apply(1, 0, 1, 8'hC1);
    apply(1, 0, 1, 8'hC2);
    apply(0, 0, 1, 8'hC3);
    apply(1, 0, 1, 8'hC4);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      apply($urandom_range(0, 99) >= 4,
            $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 70,
            W'($urandom));
    end

    // Bounded drain: both scoreboards must empty within two clocks.
    repeat (2) @(posedge C);
    #5;
    checks++;
    if (exp_f.size() == 0 && exp_r.size() == 0) begin
      passed++;
    end else begin
      $display("FAIL drain: got pending fall=%0d rise=%0d, expected 0 and 0",
               exp_f.size(), exp_r.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
